// File: rtl/ch0re_mmio_responder.sv
// ch0re_mmio_responder
// Device-side responder for the MEM-stage load/store port. It decodes a
// 32-byte window holding four 64-bit registers: TOHOST (halt/pass/test
// number), CYCLE (free-running counter), CONSOLE (TX FIFO push) and STATUS
// (FIFO count/full/overflow). Load data, error pulses and TOHOST status are
// registered. The console FIFO drains over a valid/ready byte stream.

module ch0re_mmio_responder #(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_4000_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    input  logic [1:0]  i_data_type,
    output logic        o_hit,
    output logic        o_rvalid,
    output logic [63:0] o_rdata,
    output logic        o_err,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_halt,
    output logic        o_pass,
    output logic [62:0] o_test_num
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // Register index inside the window, taken from offset bits [4:3].
    typedef enum logic [1:0] {
        REG_TOHOST  = 2'd0,
        REG_CYCLE   = 2'd1,
        REG_CONSOLE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]      tohost_q,  tohost_d;
    logic [63:0]      cycle_q,   cycle_d;
    logic             halt_q,    halt_d;
    logic             pass_q,    pass_d;
    logic [62:0]      test_num_q, test_num_d;
    logic             ovf_q,     ovf_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic             rvalid_q,  rvalid_d;
    logic [63:0]      rdata_q,   rdata_d;
    logic             err_q,     err_d;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    reg_sel_e    reg_sel;
    logic        accept;
    logic        aligned;
    logic        illegal;
    logic        access_ok;
    logic        do_load;
    logic        st_tohost;
    logic        st_console;
    logic        st_status;
    logic [63:0] wdata_ext;
    logic [63:0] status_word;
    logic [63:0] load_data;
    logic        fifo_full;
    logic        fifo_valid;
    logic        pop;
    logic        push;
    logic        drop;
    logic        halting;

    assign o_hit   = (i_addr[63:5] == BASE_ADDR[63:5]);
    assign accept  = i_req & o_hit;
    assign aligned = (i_addr[2:0] == 3'b000);
    assign reg_sel = reg_sel_e'(i_addr[4:3]);

    // Classify the access: misalignment, stores to CYCLE and loads from
    // CONSOLE are errors and must leave every register untouched.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        illegal    = !aligned;
        if (i_we && reg_sel == REG_CYCLE)    illegal = 1'b1;
        if (!i_we && reg_sel == REG_CONSOLE) illegal = 1'b1;
        access_ok  = accept & !illegal;
        do_load    = access_ok & !i_we;
        st_tohost  = access_ok & i_we & (reg_sel == REG_TOHOST);
        st_console = access_ok & i_we & (reg_sel == REG_CONSOLE);
        st_status  = access_ok & i_we & (reg_sel == REG_STATUS);
    end

    // Zero-extend store data from the access size before any register sees it.
    always_comb begin
        wdata_ext = i_wdata;
        case (i_data_type)
            2'd0:    wdata_ext = {56'd0, i_wdata[7:0]};
            2'd1:    wdata_ext = {48'd0, i_wdata[15:0]};
            2'd2:    wdata_ext = {32'd0, i_wdata[31:0]};
            default: wdata_ext = i_wdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO flags and handshakes
    // ------------------------------------------------------------------
    assign fifo_valid = (count_q != '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign pop        = fifo_valid & i_tx_ready;
    // A push into a full FIFO still lands when the head leaves this cycle.
    assign push       = st_console & (!fifo_full | pop);
    assign drop       = st_console & fifo_full & !pop;
    assign halting    = st_tohost & !halt_q & wdata_ext[0];

    // STATUS read view: OVF at 9, FULL at 8, COUNT in the low bits.
    always_comb begin
        status_word              = '0;
        status_word[CNT_W-1:0]   = count_q;
        status_word[8]           = fifo_full;
        status_word[9]           = ovf_q;
    end

    // Load data selected from pre-edge register contents.
    always_comb begin
        load_data = '0;
        case (reg_sel)
            REG_TOHOST:  load_data = tohost_q;
            REG_CYCLE:   load_data = cycle_q;
            REG_CONSOLE: load_data = '0;
            REG_STATUS:  load_data = status_word;
            default:     load_data = '0;
        endcase
    end

    // Next-state computation for all architectural registers and responses.
    always_comb begin
        tohost_d   = tohost_q;
        halt_d     = halt_q;
        pass_d     = pass_q;
        test_num_d = test_num_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        // Counter freezes once the test has signalled completion.
        cycle_d = halt_q ? cycle_q : cycle_q + 64'd1;

        // TOHOST is write-once in effect: everything after halt is ignored.
        if (st_tohost && !halt_q) begin
            tohost_d = wdata_ext;
        end
        if (halting) begin
            halt_d     = 1'b1;
            pass_d     = (wdata_ext == 64'd1);
            test_num_d = wdata_ext[63:1];
        end

        if (drop)                          ovf_d = 1'b1;
        if (st_status && wdata_ext[9])     ovf_d = 1'b0;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        rvalid_d = do_load;
        rdata_d  = do_load ? load_data : '0;
        err_d    = accept & illegal;
    end

    // ------------------------------------------------------------------
    // Sequential state with synchronous reset
    // ------------------------------------------------------------------

    // Register update; reset clears everything and discards any access.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            tohost_q   <= '0;
            cycle_q    <= '0;
            halt_q     <= 1'b0;
            pass_q     <= 1'b0;
            test_num_q <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            tohost_q   <= tohost_d;
            cycle_q    <= cycle_d;
            halt_q     <= halt_d;
            pass_q     <= pass_d;
            test_num_q <= test_num_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the byte array is deliberately not reset; emptiness is
        // tracked by COUNT, and the head output is masked while empty.
        if (push && !rst) begin
            fifo_mem_q[wr_ptr_q] <= wdata_ext[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_rvalid   = rvalid_q;
    assign o_rdata    = rdata_q;
    assign o_err      = err_q;
    assign o_tx_valid = fifo_valid;
    assign o_tx_data  = fifo_valid ? fifo_mem_q[rd_ptr_q] : 8'd0;
    assign o_halt     = halt_q;
    assign o_pass     = pass_q;
    assign o_test_num = test_num_q;

endmodule
